// File: rtl/ram_4bit_pkg.sv
// Shared defaults and state encoding for the 4-bit RAM stream reader.
package ram_4bit_pkg;

  localparam int DATA_WIDTH_DEFAULT = 4;
  localparam int ADDR_WIDTH_DEFAULT = 7;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    DONE
  } reader_state_t;

endpackage

// File: rtl/ram_4bit_skid_fifo.sv
// Two-entry FIFO between RAM read data and the output stream; head is the stream word.
module ram_4bit_skid_fifo #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             async_clear_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem_q [2];
  logic             rd_q;
  logic             wr_q;

  always_ff @(posedge clk or negedge async_clear_n) begin
    if (!async_clear_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      count    <= '0;
    end else begin
      if (push) begin
        mem_q[wr_q] <= push_data;
        wr_q        <= ~wr_q;
      end
      if (pop) rd_q <= ~rd_q;
      unique case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign head = mem_q[rd_q];

endmodule

// File: rtl/ram_4bit_stream_reader.sv
// Burst reader: streams len words from a registered-output RAM starting at base_addr.
// Define READER_CLEAR_ON_READ_EN to add write ports that zero each word as it is captured.
module ram_4bit_stream_reader
  import ram_4bit_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEFAULT
) (
  input  logic                  clk,
  input  logic                  async_clear_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   len,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] ram_read_addr,
  input  logic [DATA_WIDTH-1:0] ram_q,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last
`ifdef READER_CLEAR_ON_READ_EN
  ,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_write_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata
`endif
);

  localparam logic [ADDR_WIDTH:0] LEN_ONE = (ADDR_WIDTH+1)'(1);

  reader_state_t         state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH:0]   left_q, left_d;
  logic                  issue, issue_last;

  // s_a: address presented, RAM registers it next edge; s_b: word on ram_q awaiting capture
  logic s_a_valid_q, s_a_last_q;
  logic s_b_valid_q, s_b_last_q;

  logic [DATA_WIDTH:0] fifo_head;
  logic [1:0]          fifo_count;
  logic                head_last;
  logic                push, pop, room;
  logic [2:0]          fill, limit;

  assign out_valid = (fifo_count != 2'd0);
  assign pop       = out_valid & out_ready;
  assign push      = s_b_valid_q & ((fifo_count != 2'd2) | pop);

  // ram_q keeps the s_b word while the address is held, so only s_a counts as in flight
  assign fill  = {1'b0, fifo_count} + {2'b00, s_a_valid_q};
  assign limit = 3'd2 + {2'b00, pop};
  assign room  = fill < limit;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    left_d     = left_q;
    issue      = 1'b0;
    issue_last = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start && (len != '0)) begin
          issue      = 1'b1;
          issue_last = (len == LEN_ONE);
          addr_d     = base_addr;
          left_d     = len - 1'b1;
          state_d    = READ;
        end
      end
      READ: begin
        if (left_q == '0) begin
          state_d = DRAIN;
        end else if (room) begin
          issue      = 1'b1;
          issue_last = (left_q == LEN_ONE);
          addr_d     = addr_q + 1'b1;
          left_d     = left_q - 1'b1;
          if (left_q == LEN_ONE) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && out_last) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge async_clear_n) begin
    if (!async_clear_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      left_q      <= '0;
      s_a_valid_q <= 1'b0;
      s_a_last_q  <= 1'b0;
      s_b_valid_q <= 1'b0;
      s_b_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      left_q      <= left_d;
      s_a_valid_q <= issue;
      s_a_last_q  <= issue & issue_last;
      if (s_a_valid_q) begin
        s_b_valid_q <= 1'b1;
        s_b_last_q  <= s_a_last_q;
      end else if (push) begin
        s_b_valid_q <= 1'b0;
      end
    end
  end

  ram_4bit_skid_fifo #(
    .WIDTH(DATA_WIDTH + 1)
  ) u_fifo (
    .clk          (clk),
    .async_clear_n(async_clear_n),
    .push         (push),
    .push_data    ({s_b_last_q, ram_q}),
    .pop          (pop),
    .head         (fifo_head),
    .count        (fifo_count)
  );

  assign {head_last, out_data} = fifo_head;
  assign out_last      = out_valid & head_last;
  assign busy          = (state_q != IDLE);
  assign done          = (state_q == DONE);
  assign ram_read_addr = addr_q;

`ifdef READER_CLEAR_ON_READ_EN
  logic [ADDR_WIDTH-1:0] s_b_addr_q;

  always_ff @(posedge clk or negedge async_clear_n) begin
    if (!async_clear_n) s_b_addr_q <= '0;
    else if (s_a_valid_q) s_b_addr_q <= addr_q;
  end

  assign ram_we         = push;
  assign ram_write_addr = s_b_addr_q;
  assign ram_wdata      = '0;
`endif

endmodule

// File: tb/tb_ram_4bit_stream_reader.sv
// Randomised bench for ram_4bit_stream_reader against a list-based reference of each burst.
module tb_ram_4bit_stream_reader;

  localparam int DW    = 4;
  localparam int AW    = 7;
  localparam int DEPTH = 128;

  logic          clk = 1'b0;
  logic          async_clear_n;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   len;
  logic          busy, done;
  logic [AW-1:0] ram_read_addr;
  logic [DW-1:0] ram_q;
  logic [DW-1:0] out_data;
  logic          out_valid, out_ready, out_last;
`ifdef READER_CLEAR_ON_READ_EN
  logic          ram_we;
  logic [AW-1:0] ram_write_addr;
  logic [DW-1:0] ram_wdata;
`endif

  logic [DW-1:0] ram [DEPTH];
  logic [AW-1:0] ram_addr_q;
  logic          reload_req;
  logic [DW-1:0] ref_mem [DEPTH];

  int n_vec = 0;
  int n_err = 0;

  ram_4bit_stream_reader #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk          (clk),
    .async_clear_n(async_clear_n),
    .start        (start),
    .base_addr    (base_addr),
    .len          (len),
    .busy         (busy),
    .done         (done),
    .ram_read_addr(ram_read_addr),
    .ram_q        (ram_q),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_last     (out_last)
`ifdef READER_CLEAR_ON_READ_EN
    ,
    .ram_we        (ram_we),
    .ram_write_addr(ram_write_addr),
    .ram_wdata     (ram_wdata)
`endif
  );

  always #5 clk = ~clk;

  // Synchronous-read RAM: address registered, data read from the registered address
  always @(posedge clk) begin
    ram_addr_q <= ram_read_addr;
    if (reload_req) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= DW'(i % 16);
    end
`ifdef READER_CLEAR_ON_READ_EN
    else if (ram_we) ram[ram_write_addr] <= ram_wdata;
`endif
  end
  assign ram_q = ram[ram_addr_q];

  task automatic check_val(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic reload_mem();
    reload_req = 1'b1;
    @(negedge clk);
    reload_req = 1'b0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = DW'(i % 16);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_busy"}, int'(busy), 0);
    check_val({tag, "_done"}, int'(done), 0);
    check_val({tag, "_valid"}, int'(out_valid), 0);
    check_val({tag, "_last"}, int'(out_last), 0);
    check_val({tag, "_data"}, int'(out_data), 0);
    check_val({tag, "_raddr"}, int'(ram_read_addr), 0);
  endtask

  // mode: 0 ready held high, 1 ready pattern 1,0,0, 2 random ready
  task automatic run_burst(input int base, input int n, input int mode, input int abort_at,
                           input bit poke);
    int            exp_data[$];
    int            hs = 0;
    int            cyc = 0;
    bit            stalled = 1'b0;
    bit            rdy;
    logic [DW-1:0] held = '0;
    for (int i = 0; i < n; i++) exp_data.push_back(int'(ref_mem[(base + i) % DEPTH]));
    @(negedge clk);
    start     = 1'b1;
    base_addr = AW'(base);
    len       = (AW+1)'(n);
    @(negedge clk);
    start = 1'b0;
    check_val("addr_after_start", int'(ram_read_addr), base);
    check_val("busy_after_start", int'(busy), 1);
    while (hs < n && cyc < 1000) begin
      if (stalled) begin
        check_val("stall_valid", int'(out_valid), 1);
        check_val("stall_data", int'(out_data), int'(held));
      end
      if (cyc < 2) check_val("early_valid", int'(out_valid), 0);
      if (cyc == 2) check_val("first_valid", int'(out_valid), 1);
      if (abort_at == hs && out_valid) begin
        async_clear_n = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        @(negedge clk);
        async_clear_n = 1'b1;
        return;
      end
      if (poke && cyc == 3) begin
        start     = 1'b1;
        base_addr = AW'(base + 50);
        len       = (AW+1)'(5);
      end else begin
        start = 1'b0;
      end
      if (mode == 0) rdy = 1'b1;
      else if (mode == 1) rdy = (cyc % 3 == 0);
      else rdy = 1'($urandom_range(0, 1));
      out_ready = rdy;
      if (out_valid && rdy) begin
        check_val($sformatf("data[%0d]@%0d", hs, base), int'(out_data), exp_data[hs]);
        check_val($sformatf("last[%0d]", hs), int'(out_last), int'(hs == n - 1));
        if (mode == 0) check_val("throughput", cyc, hs + 2);
        hs++;
        stalled = 1'b0;
      end else begin
        stalled = out_valid;
      end
      held = out_data;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    if (hs < n) begin
      check_val("burst_timeout", hs, n);
    end else begin
      check_val("done_pulse", int'(done), 1);
      @(negedge clk);
      check_val("done_low", int'(done), 0);
      check_val("busy_low", int'(busy), 0);
      check_val("no_extra_word", int'(out_valid), 0);
`ifdef READER_CLEAR_ON_READ_EN
      for (int i = 0; i < n; i++) ref_mem[(base + i) % DEPTH] = '0;
`endif
    end
  endtask

  initial begin
    async_clear_n = 1'b0;
    start         = 1'b0;
    base_addr     = '0;
    len           = '0;
    out_ready     = 1'b0;
    reload_mem();
    @(negedge clk);
    check_reset_outputs("reset");
    async_clear_n = 1'b1;
    @(negedge clk);

    run_burst(5, 4, 0, -1, 1'b0);
    run_burst(126, 4, 0, -1, 1'b0);
    run_burst(20, 6, 1, -1, 1'b0);
    run_burst(60, 12, 0, -1, 1'b1);

    @(negedge clk);
    start     = 1'b1;
    base_addr = AW'(9);
    len       = '0;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_val("len0_busy", int'(busy), 0);
      check_val("len0_valid", int'(out_valid), 0);
      @(negedge clk);
    end

    run_burst(40, 10, 0, 2, 1'b0);
    for (int i = 0; i < 4; i++) begin
      check_val("post_reset_quiet", int'(out_valid), 0);
      @(negedge clk);
    end
    run_burst(0, 2, 0, -1, 1'b0);

    reload_mem();
    for (int k = 0; k < 12; k++) begin
      int b, n;
      b = int'($urandom_range(0, DEPTH - 1));
      n = (k == 5) ? DEPTH : int'($urandom_range(1, 20));
      run_burst(b, n, int'($urandom_range(0, 2)), -1, 1'b0);
    end

`ifdef READER_CLEAR_ON_READ_EN
    begin
      int nz = 0;
      reload_mem();
      run_burst(0, DEPTH, 0, -1, 1'b0);
      @(negedge clk);
      for (int i = 0; i < DEPTH; i++) if (ram[i] != '0) nz++;
      check_val("ram_cleared", nz, 0);
      run_burst(0, DEPTH, 2, -1, 1'b0);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
